// File: rtl/prd_release_queue.sv
// In-order queue of each renamed instruction's old physical destination and write flag.
// Drives the freelist release path on retirement and the rewind path on redirect walks.
module prd_release_queue #(
  parameter int FETCH_WIDTH  = 4,
  parameter int COMMIT_WIDTH = 4,
  parameter int PREG_WIDTH   = 7,
  parameter int DEPTH        = 64,
  parameter int CW           = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [FETCH_WIDTH-1:0]              enq_en,
  input  logic [FETCH_WIDTH-1:0]              enq_we,
  input  logic [FETCH_WIDTH*PREG_WIDTH-1:0]   enq_old_prd,
  output logic                                enq_ready,
  input  logic [$clog2(COMMIT_WIDTH):0]       commit_num,
  input  logic                                redirect,
  input  logic [CW-1:0]                       redirect_num,
  output logic [COMMIT_WIDTH-1:0]             commit_en,
  output logic [COMMIT_WIDTH-1:0]             commit_we,
  output logic [COMMIT_WIDTH*PREG_WIDTH-1:0]  commit_prd,
  output logic [$clog2(COMMIT_WIDTH):0]       commit_wenum,
  output logic                                walk,
  output logic [$clog2(COMMIT_WIDTH):0]       walk_wenum,
  output logic [CW-1:0]                       count,
  output logic                                walking
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(COMMIT_WIDTH) + 1;

  typedef enum logic {IDLE, WALK} state_t;

  state_t                          state, state_next;
  logic [AW-1:0]                   head, tail, head_next, tail_next;
  logic [CW-1:0]                   remain, remain_next, count_next;
  logic [CW-1:0]                   commit_cnt, enq_cnt, step, avail;
  logic                            accept;
  logic [AW-1:0]                   enq_addr [FETCH_WIDTH];
  logic [NW-1:0]                   step_wenum, c_wenum;
  logic [COMMIT_WIDTH-1:0]         c_en, c_we;
  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] c_prd;

  logic [PREG_WIDTH-1:0]           prd_mem [DEPTH];
  logic [DEPTH-1:0]                we_mem;

  assign enq_ready = (state == IDLE) && ((CW'(DEPTH) - count) >= CW'(FETCH_WIDTH));
  assign walking   = (state == WALK);

  always_comb begin
    state_next  = state;
    remain_next = remain;
    commit_cnt  = '0;
    enq_cnt     = '0;
    step        = '0;
    avail       = '0;
    step_wenum  = '0;
    c_en        = '0;
    c_we        = '0;
    c_prd       = '0;
    c_wenum     = '0;

    // Valid slots are packed densely behind tail in slot order.
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      enq_addr[s] = tail + AW'(enq_cnt);
      enq_cnt     = enq_cnt + CW'(enq_en[s]);
    end
    accept = enq_ready && !redirect;

    unique case (state)
      IDLE: begin
        commit_cnt = CW'(commit_num);
        if (redirect) begin
          avail       = count - commit_cnt;
          remain_next = (redirect_num < avail) ? redirect_num : avail;
          if (remain_next != '0) state_next = WALK;
        end
      end
      WALK: begin
        step        = (remain < CW'(COMMIT_WIDTH)) ? remain : CW'(COMMIT_WIDTH);
        remain_next = remain - step;
        if (remain_next == '0) state_next = IDLE;
      end
    endcase

    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (CW'(j) < step) step_wenum = step_wenum + NW'(we_mem[tail - AW'(j + 1)]);
    end

    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      c_en[i] = CW'(i) < commit_cnt;
      c_we[i] = c_en[i] & we_mem[head + AW'(i)];
      c_prd[i*PREG_WIDTH +: PREG_WIDTH] = c_en[i] ? prd_mem[head + AW'(i)] : '0;
      c_wenum = c_wenum + NW'(c_we[i]);
    end

    head_next  = head + AW'(commit_cnt);
    tail_next  = accept ? tail + AW'(enq_cnt) : tail - AW'(step);
    count_next = count + (accept ? enq_cnt : '0) - commit_cnt - step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      remain <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      remain <= remain_next;
      head   <= head_next;
      tail   <= tail_next;
      count  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_en    <= '0;
      commit_we    <= '0;
      commit_prd   <= '0;
      commit_wenum <= '0;
      walk         <= 1'b0;
      walk_wenum   <= '0;
    end else begin
      commit_en    <= c_en;
      commit_we    <= c_we;
      commit_prd   <= c_prd;
      commit_wenum <= c_wenum;
      walk         <= (state == WALK);
      walk_wenum   <= step_wenum;
    end
  end

  // Entry storage carries no reset; only slots between head and tail are meaningful.
  always_ff @(posedge clk) begin
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      if (accept && enq_en[s]) begin
        prd_mem[enq_addr[s]] <= enq_old_prd[s*PREG_WIDTH +: PREG_WIDTH];
        we_mem[enq_addr[s]]  <= enq_we[s];
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (commit_num <= ($clog2(COMMIT_WIDTH) + 1)'(COMMIT_WIDTH));
      if (state == IDLE) assert (CW'(commit_num) <= count);
      if (state == WALK) begin
        assert (commit_num == '0);
        assert (!redirect);
      end
    end
  end

endmodule

// File: tb/tb_prd_release_queue.sv
// Randomized and directed bench for prd_release_queue, checked against a queue-based model.
module tb_prd_release_queue;

  localparam int FW    = 4;
  localparam int CWID  = 4;
  localparam int PW    = 7;
  localparam int DEPTH = 64;
  localparam int CW    = 7;

  bit              clk = 1'b0;
  logic            rst = 1'b1;
  logic [FW-1:0]   enq_en = '0;
  logic [FW-1:0]   enq_we = '0;
  logic [FW*PW-1:0] enq_old_prd = '0;
  logic            enq_ready;
  logic [2:0]      commit_num = '0;
  logic            redirect = 1'b0;
  logic [CW-1:0]   redirect_num = '0;
  logic [CWID-1:0] commit_en, commit_we;
  logic [CWID*PW-1:0] commit_prd;
  logic [2:0]      commit_wenum;
  logic            walk;
  logic [2:0]      walk_wenum;
  logic [CW-1:0]   count;
  logic            walking;

  prd_release_queue dut (
    .clk(clk), .rst(rst),
    .enq_en(enq_en), .enq_we(enq_we), .enq_old_prd(enq_old_prd), .enq_ready(enq_ready),
    .commit_num(commit_num), .redirect(redirect), .redirect_num(redirect_num),
    .commit_en(commit_en), .commit_we(commit_we), .commit_prd(commit_prd),
    .commit_wenum(commit_wenum), .walk(walk), .walk_wenum(walk_wenum),
    .count(count), .walking(walking)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [PW-1:0] prd;
  } ent_t;

  ent_t q[$];
  bit   m_walking = 1'b0;
  int   m_remain  = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [CWID-1:0]    exp_cen, exp_cwe;
  logic [CWID*PW-1:0] exp_cprd;
  int                 exp_cwenum, exp_wwenum;
  bit                 exp_walk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus; the model predicts the state visible just after the edge.
  task automatic applyStimulus(input bit r, input logic [3:0] en, input logic [3:0] we,
                               input logic [27:0] prd, input int cnum, input bit redir,
                               input int rnum);
    bit   ready_now;
    int   step, n;
    ent_t e;
    rst = r; enq_en = en; enq_we = we; enq_old_prd = prd;
    commit_num = 3'(cnum); redirect = redir; redirect_num = 7'(rnum);

    exp_cen = '0; exp_cwe = '0; exp_cprd = '0; exp_cwenum = 0; exp_walk = 0; exp_wwenum = 0;
    ready_now = !m_walking && (DEPTH - q.size() >= FW);
    if (r) begin
      q.delete();
      m_walking = 0;
      m_remain  = 0;
    end else if (m_walking) begin
      step = (m_remain < CWID) ? m_remain : CWID;
      for (int k = 0; k < step; k++) begin
        e = q.pop_back();
        exp_wwenum += int'(e.we);
      end
      exp_walk = 1;
      m_remain -= step;
      if (m_remain == 0) m_walking = 0;
    end else begin
      for (int i = 0; i < cnum; i++) begin
        e = q.pop_front();
        exp_cen[i] = 1'b1;
        exp_cwe[i] = e.we;
        exp_cprd[i*PW +: PW] = e.prd;
        exp_cwenum += int'(e.we);
      end
      if (redir) begin
        n = (rnum < q.size()) ? rnum : q.size();
        if (n > 0) begin
          m_walking = 1;
          m_remain  = n;
        end
      end else if (ready_now) begin
        for (int s = 0; s < FW; s++) begin
          if (en[s]) begin
            e.we  = we[s];
            e.prd = prd[s*PW +: PW];
            q.push_back(e);
          end
        end
      end
    end

    @(posedge clk);
    #1;
    checkOutput("count", count, q.size());
    checkOutput("enq_ready", enq_ready, !m_walking && (DEPTH - q.size() >= FW));
    checkOutput("walking", walking, m_walking);
    checkOutput("commit_en", commit_en, exp_cen);
    checkOutput("commit_we", commit_we, exp_cwe);
    checkOutput("commit_prd", commit_prd, exp_cprd);
    checkOutput("commit_wenum", commit_wenum, exp_cwenum);
    checkOutput("walk", walk, exp_walk);
    checkOutput("walk_wenum", walk_wenum, exp_wwenum);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 4'b0, 4'b0, 28'b0, 0, 0, 0);
  endtask

  task automatic resetCycle();
    applyStimulus(1, 4'b0, 4'b0, 28'b0, 0, 0, 0);
  endtask

  task automatic enqueueN(input int n, input logic [3:0] we, input int base);
    logic [27:0] prd;
    logic [3:0]  en;
    prd = '0;
    en  = '0;
    for (int s = 0; s < FW; s++) begin
      prd[s*PW +: PW] = 7'(base + s);
      if (s < n) en[s] = 1'b1;
    end
    applyStimulus(0, en, we, prd, 0, 0, 0);
  endtask

  initial begin
    int p, cn, mx, guard;
    logic [27:0] rp;

    resetCycle();
    resetCycle();

    // Slot compaction and first commit.
    rp = {7'd9, 7'd100, 7'd6, 7'd5};
    applyStimulus(0, 4'b1011, 4'b1001, rp, 0, 0, 0);
    checkOutput("tp1_count", count, 3);
    applyStimulus(0, 4'b0, 4'b0, 28'b0, 3, 0, 0);
    checkOutput("tp1_en", commit_en, 4'b0111);
    checkOutput("tp1_we", commit_we, 4'b0101);
    checkOutput("tp1_prd", commit_prd[20:0], {7'd9, 7'd6, 7'd5});
    checkOutput("tp1_wenum", commit_wenum, 2);
    idleCycle();

    // Fill to the ready threshold and then to full.
    for (int c = 0; c < 15; c++) enqueueN(4, 4'($urandom), c * 4);
    checkOutput("ready_at_60", enq_ready, 1);
    enqueueN(1, 4'b1, 60);
    checkOutput("ready_at_61", enq_ready, 0);
    enqueueN(4, 4'hF, 70);
    applyStimulus(0, 4'b0, 4'b0, 28'b0, 4, 0, 0);
    checkOutput("ready_after_commit", enq_ready, 1);
    enqueueN(3, 4'b0101, 80);
    enqueueN(4, 4'b1010, 90);
    checkOutput("full_count", count, 64);
    enqueueN(4, 4'hF, 110);
    for (int c = 0; c < 16; c++) applyStimulus(0, 4'b0, 4'b0, 28'b0, 4, 0, 0);

    // Continuous enqueue/commit across the index wrap.
    p = 0;
    for (int c = 0; c < 40; c++) begin
      cn = (q.size() >= 4) ? 4 : 0;
      rp = '0;
      for (int s = 0; s < FW; s++) rp[s*PW +: PW] = 7'(p + s);
      applyStimulus(0, 4'hF, 4'($urandom), rp, cn, 0, 0);
      p += 4;
    end
    while (q.size() > 0) applyStimulus(0, 4'b0, 4'b0, 28'b0, (q.size() < 4) ? q.size() : 4, 0, 0);

    // Walk of 6 over a 10-entry queue.
    resetCycle();
    enqueueN(4, 4'b1101, 0);
    enqueueN(4, 4'b1101, 4);
    enqueueN(2, 4'b0010, 8);
    applyStimulus(0, 4'b0, 4'b0, 28'b0, 0, 1, 6);
    guard = 0;
    while (m_walking && guard < 20) begin
      checkOutput("ready_low_in_walk", enq_ready, 0);
      idleCycle();
      guard++;
    end
    checkOutput("walk_bounded", guard, 2);
    idleCycle();
    checkOutput("walk_count", count, 4);

    // Redirect larger than occupancy saturates.
    resetCycle();
    enqueueN(4, 4'b1111, 0);
    enqueueN(3, 4'b0101, 4);
    applyStimulus(0, 4'b0, 4'b0, 28'b0, 0, 1, 20);
    for (int c = 0; c < 3; c++) idleCycle();
    checkOutput("sat_count", count, 0);

    // Same-cycle commit and redirect.
    resetCycle();
    enqueueN(4, 4'b0110, 0);
    enqueueN(3, 4'b0111, 4);
    applyStimulus(0, 4'hF, 4'hF, 28'b0, 2, 1, 7);
    for (int c = 0; c < 3; c++) idleCycle();
    checkOutput("commit_walk_count", count, 0);

    // Reset during a walk.
    resetCycle();
    for (int c = 0; c < 3; c++) enqueueN(4, 4'($urandom), c * 4);
    applyStimulus(0, 4'b0, 4'b0, 28'b0, 0, 1, 12);
    idleCycle();
    resetCycle();
    checkOutput("rst_walk_ready", enq_ready, 1);
    idleCycle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        resetCycle();
      end else if (m_walking) begin
        applyStimulus(0, 4'($urandom), 4'($urandom), 28'($urandom), 0, 0, 0);
      end else begin
        mx = (q.size() < 4) ? q.size() : 4;
        applyStimulus(0, 4'($urandom), 4'($urandom), 28'($urandom),
                      $urandom_range(0, mx), ($urandom_range(0, 9) == 0),
                      $urandom_range(0, 40));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
